// File: rtl/seq_comparator.sv
// Slice-serial magnitude comparator: compares A and B SLICE bits per cycle, MSB slice first.
// Define SEQ_COMPARATOR_EARLY_EXIT_EN to finish as soon as the deciding slice is found.
module seq_comparator #(
   parameter int WIDTH  = 16,
   parameter int SLICE  = 4,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             Gt,
   output logic             Eq,
   output logic             Lt,
   output logic [1:0]       state_dbg
);

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   // Flipping both sign bits maps two's-complement order onto unsigned order.
   localparam logic [WIDTH-1:0] SIGN_MASK = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  a_r, b_r;
   logic [IW-1:0]     idx;
   logic              dec_gt, dec_lt;
   logic [SLICE-1:0]  slice_a, slice_b;
   logic              slice_gt, slice_lt, decided, last, accept;
   logic              fin_gt, fin_lt;

   assign slice_a  = a_r[32'(idx)*SLICE +: SLICE];
   assign slice_b  = b_r[32'(idx)*SLICE +: SLICE];
   assign slice_gt = slice_a > slice_b;
   assign slice_lt = slice_a < slice_b;
   assign decided  = dec_gt | dec_lt;
   assign last     = (idx == '0);
   assign accept   = start && (state != RUN);
   assign fin_gt   = decided ? dec_gt : slice_gt;
   assign fin_lt   = decided ? dec_lt : slice_lt;

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start) state_n = RUN;
         RUN: begin
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
            if (last || slice_gt || slice_lt) state_n = DONE;
`else
            if (last) state_n = DONE;
`endif
         end
         DONE:    state_n = start ? RUN : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         idx    <= '0;
         dec_gt <= 1'b0;
         dec_lt <= 1'b0;
         Gt     <= 1'b0;
         Eq     <= 1'b0;
         Lt     <= 1'b0;
      end else if (accept) begin
         a_r    <= A ^ SIGN_MASK;
         b_r    <= B ^ SIGN_MASK;
         idx    <= IW'(N - 1);
         dec_gt <= 1'b0;
         dec_lt <= 1'b0;
         Gt     <= 1'b0;
         Eq     <= 1'b0;
         Lt     <= 1'b0;
      end else if (state == RUN) begin
         idx <= idx - 1'b1;
         // Only the first differing slice may set the decision.
         if (!decided) begin
            dec_gt <= slice_gt;
            dec_lt <= slice_lt;
         end
         if (state_n == DONE) begin
            Gt <= fin_gt;
            Lt <= fin_lt;
            Eq <= !(fin_gt || fin_lt);
         end
      end
   end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=16, SLICE=4): unsigned and signed instances side by side.
module tb_seq_comparator;

   logic        clk, rst_n, start;
   logic [15:0] a_in, b_in;
   logic        busy_u, done_u, gt_u, eq_u, lt_u;
   logic        busy_s, done_s, gt_s, eq_s, lt_s;
   logic [1:0]  st_u, st_s;
   bit          sel;
   logic        busy_m, done_m;
   logic [2:0]  res_m;
   logic [1:0]  st_m;
   int          checks = 0;
   int          errors = 0;

   seq_comparator #(.WIDTH(16), .SLICE(4), .SIGNED(0)) u_uns (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
      .busy(busy_u), .done(done_u), .Gt(gt_u), .Eq(eq_u), .Lt(lt_u), .state_dbg(st_u));

   seq_comparator #(.WIDTH(16), .SLICE(4), .SIGNED(1)) u_sgn (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
      .busy(busy_s), .done(done_s), .Gt(gt_s), .Eq(eq_s), .Lt(lt_s), .state_dbg(st_s));

   assign busy_m = sel ? busy_s : busy_u;
   assign done_m = sel ? done_s : done_u;
   assign res_m  = sel ? {gt_s, eq_s, lt_s} : {gt_u, eq_u, lt_u};
   assign st_m   = sel ? st_s : st_u;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      bit          sg;
      logic [2:0]  res;   // {Gt, Eq, Lt}
      int          fd;    // order of first differing slice, 4 = none
   } vec_t;

   vec_t vecs[10];

   function automatic int exp_lat(input int fd);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
      return (fd >= 4) ? 5 : fd + 2;
`else
      return 5;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one comparison; returns with the bench sitting in the done cycle (or timeout).
   task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input bit sg,
                          input bit mutate, input bit poke, output int lat);
      sel   = sg;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      chk("busy_first_run", {31'd0, busy_m}, 32'd1);
      if (mutate) begin
         a_in = 16'hFFFF;
         b_in = 16'hFFFF;
      end
      while (!done_m && lat < 20) begin
         start = (poke && lat == 2);
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      if (!done_m) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic post_checks(input string name, input logic [2:0] res);
      chk({name, "_busy_in_done"}, {31'd0, busy_m}, 32'd0);
      @(posedge clk); #1;
      chk({name, "_done_one_cycle"}, {31'd0, done_m}, 32'd0);
      chk({name, "_state_idle"}, {30'd0, st_m}, 32'd0);
      chk({name, "_res_held"}, {29'd0, res_m}, {29'd0, res});
   endtask

   initial begin
      int lat;
      int seen;
      vecs[0] = '{16'h1234, 16'h1234, 1'b0, 3'b010, 4};
      vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 0};
      vecs[2] = '{16'h8000, 16'h0001, 1'b1, 3'b001, 0};
      vecs[3] = '{16'h8000, 16'h0001, 1'b0, 3'b100, 0};
      vecs[4] = '{16'h0010, 16'h0011, 1'b0, 3'b001, 3};
      vecs[5] = '{16'h0500, 16'h0400, 1'b0, 3'b100, 1};
      vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 3'b001, 0};
      vecs[7] = '{16'h7FFF, 16'h7FFE, 1'b1, 3'b100, 3};
      vecs[8] = '{16'hABCD, 16'hAB0D, 1'b0, 3'b100, 2};
      vecs[9] = '{16'h1234, 16'h1234, 1'b1, 3'b010, 4};

      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      sel   = 1'b0;
      #1;
      chk("reset_outputs_uns", {27'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 32'd0);
      chk("reset_outputs_sgn", {27'd0, busy_s, done_s, gt_s, eq_s, lt_s}, 32'd0);
      chk("reset_state", {30'd0, st_u}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // table-driven vectors
      for (int i = 0; i < 10; i++) begin
         run_cmp(vecs[i].a, vecs[i].b, vecs[i].sg, 1'b0, 1'b0, lat);
         chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].fd));
         chk($sformatf("vec%0d_result", i), {29'd0, res_m}, {29'd0, vecs[i].res});
         post_checks($sformatf("vec%0d", i), vecs[i].res);
      end

      // operands changed during RUN must not matter
      run_cmp(16'h0010, 16'h0011, 1'b0, 1'b1, 1'b0, lat);
      chk("mutate_latency", lat, 5);
      chk("mutate_result", {29'd0, res_m}, 32'b001);
      post_checks("mutate", 3'b001);

      // start pulsed during RUN is ignored
      run_cmp(16'h0010, 16'h0011, 1'b0, 1'b0, 1'b1, lat);
      chk("poke_latency", lat, 5);
      chk("poke_result", {29'd0, res_m}, 32'b001);
      post_checks("poke", 3'b001);

      // back-to-back: start held across DONE
      run_cmp(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, lat);
      chk("b2b_first_result", {29'd0, res_m}, 32'b100);
      a_in  = 16'h0010;
      b_in  = 16'h0011;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", {31'd0, busy_m}, 32'd1);
      chk("b2b_cleared", {29'd0, res_m}, 32'd0);
      chk("b2b_state_run", {30'd0, st_m}, 32'd1);
      lat = 1;
      while (!done_m && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_latency", lat, 5);
      chk("b2b_result", {29'd0, res_m}, 32'b001);
      post_checks("b2b", 3'b001);

      // reset during the second RUN cycle
      sel   = 1'b0;
      a_in  = 16'h0010;
      b_in  = 16'h0011;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("midrun_busy_before", {31'd0, busy_u}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", {27'd0, busy_u, done_u, gt_u, eq_u, lt_u}, 32'd0);
      chk("midrun_reset_state", {30'd0, st_u}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done_u || busy_u) seen++;
      end
      chk("midrun_no_done_after", seen, 0);

      // start accepted on the first edge after reset release
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_cmp(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, lat);
      chk("post_reset_latency", lat, 5);
      chk("post_reset_result", {29'd0, res_m}, 32'b010);
      post_checks("post_reset", 3'b010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
